// File: rtl/cpu_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// cpu_ctrl_fsm
// Multi-cycle control unit for the 8-bit RISC core. Sequences
// FETCH -> DECODE -> EXEC -> (MEM -> (WB)) and drives the PC, IR, regfile,
// ALU and data-memory strobes. HALT and FAULT (memory-wait timeout) are
// terminal states left only through reset.
//
// Strobes are decoded combinationally from the state register, plus opcode/fn/
// flags/mem_ready where the instruction needs them. Because of this, an
// asynchronous reset takes every strobe, including an in-flight mem_req, low
// without waiting for a clock edge.
//
// Optional build macro: CPU_CTRL_RETIRE_CNT_EN
//   Adds a wrapping retired-instruction counter output.
//
// Parameters:
//   MEM_TO  max MEM cycles waiting for mem_ready before FAULT (1..255)
//   CNT_W   width of the retired-instruction counter
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   run        allow execution, sampled at instruction boundaries
//   opcode     decoded opcode (from registered IR)
//   fn         decoded function field
//   alu_zero   ALU result == 0
//   alu_lt     ALU signed less-than
//   mem_ready  data-memory access complete
//   ir_load    latch instruction into IR
//   pc_en      update PC this cycle
//   pc_src     00 PC+1, 01 PC+branch imm, 10 jump imm
//   alu_op     000 AND, 001 OR, 010 SRL, 011 SLL, 100 ADD, 101 SUB
//   reg_we     regfile write enable
//   wb_sel     0 ALU result, 1 memory data
//   mem_req    data-memory request
//   mem_we     1 store, 0 load (valid with mem_req)
//   retired    retired-instruction count (macro builds only)
//   halted     in HALT state
//   fault      in FAULT state (sticky until reset)
// ---------------------------------------------------------------------------
module cpu_ctrl_fsm #(
  parameter int unsigned MEM_TO = 15,
  parameter int unsigned CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic [1:0]       opcode,
  input  logic [1:0]       fn,
  input  logic             alu_zero,
  input  logic             alu_lt,
  input  logic             mem_ready,
  output logic             ir_load,
  output logic             pc_en,
  output logic [1:0]       pc_src,
  output logic [2:0]       alu_op,
  output logic             reg_we,
  output logic             wb_sel,
  output logic             mem_req,
  output logic             mem_we,
  output logic             halted,
`ifdef CPU_CTRL_RETIRE_CNT_EN
  output logic [CNT_W-1:0] retired,
`endif
  output logic             fault
);

  localparam int unsigned WAIT_W = 8;
  // Last wait-counter value before the timeout fires on a not-ready cycle.
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TO - 1);

  localparam logic [1:0] PC_INC = 2'b00;
  localparam logic [1:0] PC_BR  = 2'b01;
  localparam logic [1:0] PC_JMP = 2'b10;

  localparam logic [2:0] ALU_ADD = 3'b100;
  localparam logic [2:0] ALU_SUB = 3'b101;

  localparam logic [1:0] OP_LOGIC  = 2'b00;
  localparam logic [1:0] OP_BRANCH = 2'b01;
  localparam logic [1:0] OP_MEM    = 2'b10;
  localparam logic [1:0] OP_ARITH  = 2'b11;

  localparam logic [1:0] FN_ADD  = 2'b00;
  localparam logic [1:0] FN_JUMP = 2'b01;
  localparam logic [1:0] FN_SUB  = 2'b10;
  localparam logic [1:0] FN_HALT = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6,
    S_FAULT  = 3'd7
  } state_t;

  // Elaboration-time parameter range checks.
  if (MEM_TO == 0 || MEM_TO > 255) begin : g_bad_mem_to
    $error("cpu_ctrl_fsm: MEM_TO must be in 1..255");
  end
  if (CNT_W == 0) begin : g_bad_cnt_w
    $error("cpu_ctrl_fsm: CNT_W must be at least 1");
  end

  state_t            r_state;
  state_t            w_state_nxt;
  state_t            w_boundary;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic [WAIT_W-1:0] w_wait_nxt;

  logic w_op_logic;
  logic w_op_branch;
  logic w_op_mem;
  logic w_is_add;
  logic w_is_sub;
  logic w_is_jump;
  logic w_is_halt;
  logic w_is_store;
  logic w_br_taken;

  // Instruction class decode; opcode/fn come from the registered IR.
  assign w_op_logic  = (opcode == OP_LOGIC);
  assign w_op_branch = (opcode == OP_BRANCH);
  assign w_op_mem    = (opcode == OP_MEM);
  assign w_is_add    = (opcode == OP_ARITH) && (fn == FN_ADD);
  assign w_is_sub    = (opcode == OP_ARITH) && (fn == FN_SUB);
  assign w_is_jump   = (opcode == OP_ARITH) && (fn == FN_JUMP);
  assign w_is_halt   = (opcode == OP_ARITH) && (fn == FN_HALT);
  // fn[1] is a don't-care for branch and memory ops.
  assign w_is_store  = fn[0];
  assign w_br_taken  = fn[0] ? alu_lt : alu_zero;

  // Where an instruction goes once it has finished.
  assign w_boundary  = run ? S_FETCH : S_IDLE;

  // State and wait-counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_wait_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_nxt;
    end
  end

  // Next-state and wait-counter update.
  always_comb begin
    w_state_nxt = r_state;
    w_wait_nxt  = r_wait_cnt;
    case (r_state)
      S_IDLE: begin
        if (run) begin
          w_state_nxt = S_FETCH;
        end
      end
      S_FETCH: begin
        w_state_nxt = S_DECODE;
      end
      S_DECODE: begin
        w_state_nxt = S_EXEC;
      end
      S_EXEC: begin
        if (w_op_mem) begin
          w_state_nxt = S_MEM;
          w_wait_nxt  = '0;
        end else if (w_is_halt) begin
          w_state_nxt = S_HALT;
        end else begin
          w_state_nxt = w_boundary;
        end
      end
      S_MEM: begin
        // mem_ready on the limit cycle still completes the access.
        if (mem_ready) begin
          w_state_nxt = w_is_store ? w_boundary : S_WB;
        end else if (r_wait_cnt == WAIT_LAST) begin
          w_state_nxt = S_FAULT;
        end else begin
          w_wait_nxt = r_wait_cnt + WAIT_W'(1);
        end
      end
      S_WB: begin
        w_state_nxt = w_boundary;
      end
      S_HALT: begin
        w_state_nxt = S_HALT;
      end
      S_FAULT: begin
        w_state_nxt = S_FAULT;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Strobe decode from state (plus instruction fields in EXEC/MEM).
  always_comb begin
    ir_load = 1'b0;
    pc_en   = 1'b0;
    pc_src  = PC_INC;
    alu_op  = 3'b000;
    reg_we  = 1'b0;
    wb_sel  = 1'b0;
    mem_req = 1'b0;
    mem_we  = 1'b0;
    halted  = 1'b0;
    fault   = 1'b0;
    case (r_state)
      S_FETCH: begin
        ir_load = 1'b1;
      end
      S_EXEC: begin
        if (w_op_logic) begin
          alu_op = {1'b0, fn};
          reg_we = 1'b1;
          pc_en  = 1'b1;
        end else if (w_op_branch) begin
          alu_op = ALU_SUB;
          pc_en  = 1'b1;
          pc_src = w_br_taken ? PC_BR : PC_INC;
        end else if (w_op_mem) begin
          alu_op = ALU_ADD;
        end else if (w_is_add) begin
          alu_op = ALU_ADD;
          reg_we = 1'b1;
          pc_en  = 1'b1;
        end else if (w_is_sub) begin
          alu_op = ALU_SUB;
          reg_we = 1'b1;
          pc_en  = 1'b1;
        end else if (w_is_jump) begin
          pc_en  = 1'b1;
          pc_src = PC_JMP;
        end
        // HALT issues no strobes.
      end
      S_MEM: begin
        mem_req = 1'b1;
        mem_we  = w_is_store;
        alu_op  = ALU_ADD;
        // A store retires in MEM; a load retires in WB.
        if (mem_ready && w_is_store) begin
          pc_en = 1'b1;
        end
      end
      S_WB: begin
        reg_we = 1'b1;
        wb_sel = 1'b1;
        pc_en  = 1'b1;
      end
      S_HALT: begin
        halted = 1'b1;
      end
      S_FAULT: begin
        fault = 1'b1;
      end
      default: begin
      end
    endcase
  end

`ifdef CPU_CTRL_RETIRE_CNT_EN
  logic [CNT_W-1:0] r_retired;
  logic             w_retire;

  // Every PC update retires an instruction; HALT retires without one.
  assign w_retire = pc_en | ((r_state == S_EXEC) & w_is_halt);

  // Retired-instruction counter, wraps at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_retired <= '0;
    end else if (w_retire) begin
      r_retired <= r_retired + CNT_W'(1);
    end
  end

  assign retired = r_retired;
`endif

endmodule
